// File: rtl/frame_buffer_swapper_if.sv
// Writer, reader and swap-control signals of the frame buffer swapper.
// master = host/vga side, slave = the buffer itself.
interface frame_buffer_swapper_if #(
  parameter int DATA_W = 12,
  parameter int COL_W  = 7,
  parameter int ROW_W  = 6
);
  logic              wr_en;
  logic [COL_W-1:0]  wr_col;
  logic [ROW_W-1:0]  wr_row;
  logic [DATA_W-1:0] wr_data;
  logic              wr_frame_done;
  logic              wr_ready;
  logic              rd_en;
  logic [COL_W-1:0]  rd_col;
  logic [ROW_W-1:0]  rd_row;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              frame_start;
  logic              swap_pulse;
  logic [1:0]        front_idx;
  logic [7:0]        drop_cnt;

  modport master (
    output wr_en, wr_col, wr_row, wr_data, wr_frame_done,
    output rd_en, rd_col, rd_row, frame_start,
    input  wr_ready, rd_data, rd_valid, swap_pulse, front_idx, drop_cnt
  );

  modport slave (
    input  wr_en, wr_col, wr_row, wr_data, wr_frame_done,
    input  rd_en, rd_col, rd_row, frame_start,
    output wr_ready, rd_data, rd_valid, swap_pulse, front_idx, drop_cnt
  );
endinterface

// File: rtl/frame_buffer_swapper.sv
// Tear-free double/triple frame buffer; reads return 1 cycle after rd_en, swaps only on frame_start.
// Backpressure: NUM_BUF=2 drops wr_ready from frame done until the swap; NUM_BUF=3 never stalls.
module frame_buffer_swapper #(
  parameter int DATA_W  = 12,
  parameter int COL_W   = 7,
  parameter int ROW_W   = 6,
  parameter int NUM_BUF = 2
) (
  input logic                   clk,
  input logic                   clrn,
  frame_buffer_swapper_if.slave bus
);
  localparam int AW     = ROW_W + COL_W;
  localparam int BANK_W = (NUM_BUF > 2) ? 2 : 1;
  localparam int DEPTH  = NUM_BUF << AW;

  if (NUM_BUF != 2 && NUM_BUF != 3) begin : g_bad_num_buf
    $error("frame_buffer_swapper: NUM_BUF must be 2 or 3");
  end

  typedef enum logic {WRITING, WAIT_SWAP} state_e;

  state_e            state_q, state_d;
  logic [1:0]        front_q, front_d, back_q, back_d;
  logic [1:0]        spare_q, spare_d, pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic              swap_pulse_q, swap_pulse_d;
  logic              rd_valid_q, rd_valid_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ready, wr_fire;
  logic [BANK_W-1:0] wr_bank, rd_bank;

  assign wr_ready = (NUM_BUF == 2) ? (state_q == WRITING) : 1'b1;
  assign wr_fire  = bus.wr_en && wr_ready;
  assign wr_bank  = back_q[BANK_W-1:0];
  assign rd_bank  = front_q[BANK_W-1:0];

  // Writes use the pre-update back bank, so a write in the done cycle lands in the finished frame.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[{wr_bank, bus.wr_row, bus.wr_col}] <= bus.wr_data;
  end

  always_comb begin
    rd_data_d  = bus.rd_en ? mem[{rd_bank, bus.rd_row, bus.rd_col}] : rd_data_q;
    rd_valid_d = bus.rd_en;
  end

  always_comb begin
    state_d      = state_q;
    front_d      = front_q;
    back_d       = back_q;
    spare_d      = spare_q;
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    swap_pulse_d = 1'b0;
    drop_cnt_d   = drop_cnt_q;
    if (NUM_BUF == 2) begin
      case (state_q)
        WRITING: begin
          if (bus.wr_frame_done) begin
            if (bus.frame_start) begin
              front_d      = back_q;
              back_d       = front_q;
              swap_pulse_d = 1'b1;
            end else begin
              state_d = WAIT_SWAP;
            end
          end
        end
        WAIT_SWAP: begin
          if (bus.frame_start) begin
            front_d      = back_q;
            back_d       = front_q;
            swap_pulse_d = 1'b1;
            state_d      = WRITING;
          end
        end
        default: state_d = WRITING;
      endcase
    end else begin
      // Done is applied before start so a same-cycle completion is shown immediately.
      if (bus.wr_frame_done) begin
        if (pend_vld_q) begin
          back_d = pend_q;
          pend_d = back_q;
          if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
          pend_d     = back_q;
          back_d     = spare_q;
          pend_vld_d = 1'b1;
        end
      end
      if (bus.frame_start && pend_vld_d) begin
        front_d      = pend_d;
        spare_d      = front_q;
        pend_vld_d   = 1'b0;
        swap_pulse_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= WRITING;
      front_q      <= 2'd0;
      back_q       <= 2'd1;
      spare_q      <= 2'd2;
      pend_q       <= 2'd0;
      pend_vld_q   <= 1'b0;
      swap_pulse_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      drop_cnt_q   <= 8'd0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      front_q      <= front_d;
      back_q       <= back_d;
      spare_q      <= spare_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      swap_pulse_q <= swap_pulse_d;
      rd_valid_q   <= rd_valid_d;
      drop_cnt_q   <= drop_cnt_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign bus.wr_ready   = wr_ready;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.swap_pulse = swap_pulse_q;
  assign bus.front_idx  = front_q;
  assign bus.drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_frame_buffer_swapper.sv
// Directed bench: one double-buffered and one triple-buffered instance sharing clock and reset.
module tb_frame_buffer_swapper;
  logic clk = 1'b0;
  logic clrn = 1'b0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  frame_buffer_swapper_if #(.DATA_W(12), .COL_W(7), .ROW_W(6)) b2 ();
  frame_buffer_swapper_if #(.DATA_W(12), .COL_W(7), .ROW_W(6)) b3 ();

  frame_buffer_swapper #(.DATA_W(12), .COL_W(7), .ROW_W(6), .NUM_BUF(2)) u_dbl (
    .clk(clk), .clrn(clrn), .bus(b2.slave));
  frame_buffer_swapper #(.DATA_W(12), .COL_W(7), .ROW_W(6), .NUM_BUF(3)) u_tri (
    .clk(clk), .clrn(clrn), .bus(b3.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr2(input logic [6:0] c, input logic [5:0] r, input logic [11:0] d);
    b2.wr_en = 1'b1; b2.wr_col = c; b2.wr_row = r; b2.wr_data = d;
    tick();
    b2.wr_en = 1'b0;
  endtask

  task automatic wr3(input logic [6:0] c, input logic [5:0] r, input logic [11:0] d);
    b3.wr_en = 1'b1; b3.wr_col = c; b3.wr_row = r; b3.wr_data = d;
    tick();
    b3.wr_en = 1'b0;
  endtask

  task automatic rd2(input logic [6:0] c, input logic [5:0] r);
    b2.rd_en = 1'b1; b2.rd_col = c; b2.rd_row = r;
    tick();
    b2.rd_en = 1'b0;
  endtask

  task automatic rd3(input logic [6:0] c, input logic [5:0] r);
    b3.rd_en = 1'b1; b3.rd_col = c; b3.rd_row = r;
    tick();
    b3.rd_en = 1'b0;
  endtask

  task automatic ev2(input logic done, input logic start);
    b2.wr_frame_done = done; b2.frame_start = start;
    tick();
    b2.wr_frame_done = 1'b0; b2.frame_start = 1'b0;
  endtask

  task automatic ev3(input logic done, input logic start);
    b3.wr_frame_done = done; b3.frame_start = start;
    tick();
    b3.wr_frame_done = 1'b0; b3.frame_start = 1'b0;
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    repeat (2) tick();
    checks++; if (b2.front_idx !== 2'd0) begin errors++; $display("FAIL rst2_front: got %0d want 0", b2.front_idx); end
    checks++; if (b2.wr_ready !== 1'b1) begin errors++; $display("FAIL rst2_ready: got %b want 1", b2.wr_ready); end
    checks++; if (b2.rd_valid !== 1'b0) begin errors++; $display("FAIL rst2_valid: got %b want 0", b2.rd_valid); end
    checks++; if (b2.rd_data !== 12'h000) begin errors++; $display("FAIL rst2_data: got %h want 000", b2.rd_data); end
    checks++; if (b2.swap_pulse !== 1'b0) begin errors++; $display("FAIL rst2_swap: got %b want 0", b2.swap_pulse); end
    checks++; if (b3.front_idx !== 2'd0) begin errors++; $display("FAIL rst3_front: got %0d want 0", b3.front_idx); end
    checks++; if (b3.drop_cnt !== 8'd0) begin errors++; $display("FAIL rst3_drop: got %0d want 0", b3.drop_cnt); end
    checks++; if (b3.wr_ready !== 1'b1) begin errors++; $display("FAIL rst3_ready: got %b want 1", b3.wr_ready); end
    #2 clrn = 1'b1;
    tick();
  endtask

  task automatic test_double_buffer();
    wr2(7'd3, 6'd5, 12'hABC);
    ev2(1'b1, 1'b0);
    checks++; if (b2.wr_ready !== 1'b0) begin errors++; $display("FAIL dbl_wait_ready: got %b want 0", b2.wr_ready); end
    checks++; if (b2.front_idx !== 2'd0) begin errors++; $display("FAIL dbl_wait_front: got %0d want 0", b2.front_idx); end
    ev2(1'b0, 1'b1);
    checks++; if (b2.front_idx !== 2'd1) begin errors++; $display("FAIL dbl_front: got %0d want 1", b2.front_idx); end
    checks++; if (b2.swap_pulse !== 1'b1) begin errors++; $display("FAIL dbl_swap: got %b want 1", b2.swap_pulse); end
    checks++; if (b2.wr_ready !== 1'b1) begin errors++; $display("FAIL dbl_ready: got %b want 1", b2.wr_ready); end
    tick();
    checks++; if (b2.swap_pulse !== 1'b0) begin errors++; $display("FAIL dbl_swap_once: got %b want 0", b2.swap_pulse); end
    rd2(7'd3, 6'd5);
    checks++; if (b2.rd_data !== 12'hABC) begin errors++; $display("FAIL dbl_rdata: got %h want abc", b2.rd_data); end
    checks++; if (b2.rd_valid !== 1'b1) begin errors++; $display("FAIL dbl_rvalid: got %b want 1", b2.rd_valid); end
    tick();
    checks++; if (b2.rd_valid !== 1'b0) begin errors++; $display("FAIL dbl_rvalid_drop: got %b want 0", b2.rd_valid); end
    checks++; if (b2.rd_data !== 12'hABC) begin errors++; $display("FAIL dbl_rdata_hold: got %h want abc", b2.rd_data); end
  endtask

  task automatic test_stall();
    wr2(7'd3, 6'd5, 12'h111);
    ev2(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      b2.wr_en = 1'b1; b2.wr_col = 7'd3; b2.wr_row = 6'd5; b2.wr_data = 12'hFFF;
      b2.wr_frame_done = (i == 4);
      tick();
      checks++; if (b2.wr_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b want 0", i, b2.wr_ready); end
    end
    b2.wr_en = 1'b0; b2.wr_frame_done = 1'b0;
    ev2(1'b0, 1'b1);
    checks++; if (b2.wr_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got %b want 1", b2.wr_ready); end
    checks++; if (b2.front_idx !== 2'd0) begin errors++; $display("FAIL stall_front: got %0d want 0", b2.front_idx); end
    rd2(7'd3, 6'd5);
    checks++; if (b2.rd_data !== 12'h111) begin errors++; $display("FAIL stall_ignored_wr: got %h want 111", b2.rd_data); end
  endtask

  task automatic test_simultaneous();
    wr2(7'd7, 6'd2, 12'h5A5);
    b2.wr_en = 1'b1; b2.wr_col = 7'd3; b2.wr_row = 6'd5; b2.wr_data = 12'h777;
    ev2(1'b1, 1'b1);
    b2.wr_en = 1'b0;
    checks++; if (b2.front_idx !== 2'd1) begin errors++; $display("FAIL sim2_front: got %0d want 1", b2.front_idx); end
    checks++; if (b2.swap_pulse !== 1'b1) begin errors++; $display("FAIL sim2_swap: got %b want 1", b2.swap_pulse); end
    checks++; if (b2.wr_ready !== 1'b1) begin errors++; $display("FAIL sim2_ready: got %b want 1", b2.wr_ready); end
    rd2(7'd7, 6'd2);
    checks++; if (b2.rd_data !== 12'h5A5) begin errors++; $display("FAIL sim2_rd_a: got %h want 5a5", b2.rd_data); end
    rd2(7'd3, 6'd5);
    checks++; if (b2.rd_data !== 12'h777) begin errors++; $display("FAIL sim2_rd_b: got %h want 777", b2.rd_data); end
  endtask

  task automatic test_read_during_swap();
    ev2(1'b1, 1'b0);
    b2.rd_en = 1'b1; b2.rd_col = 7'd3; b2.rd_row = 6'd5; b2.frame_start = 1'b1;
    tick();
    b2.rd_en = 1'b0; b2.frame_start = 1'b0;
    checks++; if (b2.rd_data !== 12'h777) begin errors++; $display("FAIL rsw_old_front: got %h want 777", b2.rd_data); end
    checks++; if (b2.front_idx !== 2'd0) begin errors++; $display("FAIL rsw_front: got %0d want 0", b2.front_idx); end
    rd2(7'd3, 6'd5);
    checks++; if (b2.rd_data !== 12'h111) begin errors++; $display("FAIL rsw_new_front: got %h want 111", b2.rd_data); end
  endtask

  task automatic test_triple_drop();
    logic [11:0] fd [3];
    fd[0] = 12'hA01; fd[1] = 12'hB02; fd[2] = 12'hC03;
    for (int i = 0; i < 3; i++) begin
      wr3(7'd1, 6'd1, fd[i]);
      ev3(1'b1, 1'b0);
      checks++; if (b3.wr_ready !== 1'b1) begin errors++; $display("FAIL tri_ready[%0d]: got %b want 1", i, b3.wr_ready); end
    end
    checks++; if (b3.drop_cnt !== 8'd2) begin errors++; $display("FAIL tri_drop: got %0d want 2", b3.drop_cnt); end
    checks++; if (b3.front_idx !== 2'd0) begin errors++; $display("FAIL tri_front_hold: got %0d want 0", b3.front_idx); end
    ev3(1'b0, 1'b1);
    checks++; if (b3.front_idx !== 2'd1) begin errors++; $display("FAIL tri_front: got %0d want 1", b3.front_idx); end
    checks++; if (b3.swap_pulse !== 1'b1) begin errors++; $display("FAIL tri_swap: got %b want 1", b3.swap_pulse); end
    rd3(7'd1, 6'd1);
    checks++; if (b3.rd_data !== 12'hC03) begin errors++; $display("FAIL tri_newest: got %h want c03", b3.rd_data); end
    ev3(1'b0, 1'b1);
    checks++; if (b3.swap_pulse !== 1'b0) begin errors++; $display("FAIL tri_idle_swap: got %b want 0", b3.swap_pulse); end
    checks++; if (b3.front_idx !== 2'd1) begin errors++; $display("FAIL tri_idle_front: got %0d want 1", b3.front_idx); end
  endtask

  task automatic test_triple_simultaneous();
    wr3(7'd2, 6'd2, 12'hD04);
    ev3(1'b1, 1'b0);
    wr3(7'd2, 6'd2, 12'hE05);
    b3.wr_en = 1'b1; b3.wr_col = 7'd4; b3.wr_row = 6'd4; b3.wr_data = 12'hE55;
    ev3(1'b1, 1'b1);
    b3.wr_en = 1'b0;
    checks++; if (b3.front_idx !== 2'd0) begin errors++; $display("FAIL tsim_front: got %0d want 0", b3.front_idx); end
    checks++; if (b3.swap_pulse !== 1'b1) begin errors++; $display("FAIL tsim_swap: got %b want 1", b3.swap_pulse); end
    checks++; if (b3.drop_cnt !== 8'd3) begin errors++; $display("FAIL tsim_drop: got %0d want 3", b3.drop_cnt); end
    rd3(7'd2, 6'd2);
    checks++; if (b3.rd_data !== 12'hE05) begin errors++; $display("FAIL tsim_rd_a: got %h want e05", b3.rd_data); end
    rd3(7'd4, 6'd4);
    checks++; if (b3.rd_data !== 12'hE55) begin errors++; $display("FAIL tsim_rd_b: got %h want e55", b3.rd_data); end
  endtask

  task automatic test_reset_mid_frame();
    ev3(1'b1, 1'b1);
    wr3(7'd0, 6'd0, 12'h123);
    ev3(1'b1, 1'b0);
    ev2(1'b1, 1'b0);
    b3.rd_en = 1'b1; b3.rd_col = 7'd2; b3.rd_row = 6'd2;
    b2.rd_en = 1'b1; b2.rd_col = 7'd3; b2.rd_row = 6'd5;
    tick();
    b3.rd_en = 1'b0; b2.rd_en = 1'b0;
    checks++; if (b3.front_idx !== 2'd2) begin errors++; $display("FAIL rmid_pre_front: got %0d want 2", b3.front_idx); end
    checks++; if (b3.rd_data !== 12'hD04) begin errors++; $display("FAIL rmid_pre_data: got %h want d04", b3.rd_data); end
    #2 clrn = 1'b0;
    #1;
    checks++; if (b3.front_idx !== 2'd0) begin errors++; $display("FAIL rmid_front: got %0d want 0", b3.front_idx); end
    checks++; if (b3.drop_cnt !== 8'd0) begin errors++; $display("FAIL rmid_drop: got %0d want 0", b3.drop_cnt); end
    checks++; if (b3.rd_data !== 12'h000) begin errors++; $display("FAIL rmid_data: got %h want 000", b3.rd_data); end
    checks++; if (b3.rd_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", b3.rd_valid); end
    checks++; if (b2.wr_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready2: got %b want 1", b2.wr_ready); end
    checks++; if (b2.rd_data !== 12'h000) begin errors++; $display("FAIL rmid_data2: got %h want 000", b2.rd_data); end
    #2 clrn = 1'b1;
    b2.frame_start = 1'b1;
    ev3(1'b0, 1'b1);
    b2.frame_start = 1'b0;
    checks++; if (b3.swap_pulse !== 1'b0) begin errors++; $display("FAIL rmid_swap3: got %b want 0", b3.swap_pulse); end
    checks++; if (b3.front_idx !== 2'd0) begin errors++; $display("FAIL rmid_front3: got %0d want 0", b3.front_idx); end
    checks++; if (b2.swap_pulse !== 1'b0) begin errors++; $display("FAIL rmid_swap2: got %b want 0", b2.swap_pulse); end
  endtask

  task automatic test_drop_saturate();
    b3.wr_frame_done = 1'b1;
    repeat (255) tick();
    checks++; if (b3.drop_cnt !== 8'd254) begin errors++; $display("FAIL sat_pre: got %0d want 254", b3.drop_cnt); end
    repeat (3) tick();
    b3.wr_frame_done = 1'b0;
    checks++; if (b3.drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d want 255", b3.drop_cnt); end
    checks++; if (b3.wr_ready !== 1'b1) begin errors++; $display("FAIL sat_ready: got %b want 1", b3.wr_ready); end
  endtask

  initial begin
    b2.wr_en = 1'b0; b2.wr_col = '0; b2.wr_row = '0; b2.wr_data = '0; b2.wr_frame_done = 1'b0;
    b2.rd_en = 1'b0; b2.rd_col = '0; b2.rd_row = '0; b2.frame_start = 1'b0;
    b3.wr_en = 1'b0; b3.wr_col = '0; b3.wr_row = '0; b3.wr_data = '0; b3.wr_frame_done = 1'b0;
    b3.rd_en = 1'b0; b3.rd_col = '0; b3.rd_row = '0; b3.frame_start = 1'b0;
    test_reset();
    test_double_buffer();
    test_stall();
    test_simultaneous();
    test_read_during_swap();
    test_triple_drop();
    test_triple_simultaneous();
    test_reset_mid_frame();
    test_drop_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
